// File: rtl/rv_mul_pipeline_pkg.sv
// Shared function codes and operand-decode helper for the pipelined RV32M/RV64M multiplier.
package rv_mul_pipeline_pkg;

  localparam logic [2:0] FUNC_MUL    = 3'b000;
  localparam logic [2:0] FUNC_MULH   = 3'b001;
  localparam logic [2:0] FUNC_MULHSU = 3'b010;
  localparam logic [2:0] FUNC_MULHU  = 3'b011;

  typedef struct packed {
    logic sign_a;
    logic sign_b;
    logic low_word;
  } mul_dec_t;

  // Codes 1xx match none of the signed cases and so fall through to MULHU behaviour.
  function automatic mul_dec_t mul_decode(input logic [2:0] fun);
    mul_dec_t dec;
    dec.sign_a   = (fun == FUNC_MUL) || (fun == FUNC_MULH) || (fun == FUNC_MULHSU);
    dec.sign_b   = (fun == FUNC_MUL) || (fun == FUNC_MULH);
    dec.low_word = (fun == FUNC_MUL);
    return dec;
  endfunction

endpackage

// File: rtl/rv_mul_pipeline_if.sv
// Issue/result bundle between the execute-stage controller and the multiplier.
interface rv_mul_pipeline_if #(
  parameter int g_width = 32
);
  logic               x_stall_i;
  logic               x_kill_i;
  logic               d_valid_i;
  logic               d_is_mul_i;
  logic [2:0]         d_fun_i;
  logic [g_width-1:0] d_rs1_i;
  logic [g_width-1:0] d_rs2_i;
  logic [g_width-1:0] x_rd_o;
  logic               x_valid_o;
  logic               x_stall_req_o;

  modport master (
    output x_stall_i, x_kill_i, d_valid_i, d_is_mul_i, d_fun_i, d_rs1_i, d_rs2_i,
    input  x_rd_o, x_valid_o, x_stall_req_o
  );

  modport slave (
    input  x_stall_i, x_kill_i, d_valid_i, d_is_mul_i, d_fun_i, d_rs1_i, d_rs2_i,
    output x_rd_o, x_valid_o, x_stall_req_o
  );
endinterface

// File: rtl/rv_mul_pipe_reg.sv
// One pipeline stage: data plus valid, holding on stall and dropping valid on kill.
module rv_mul_pipe_reg #(
  parameter int g_w        = 8,
  parameter bit g_rst_data = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           stall,
  input  logic           kill,
  input  logic           vld_in,
  input  logic [g_w-1:0] d,
  output logic           vld,
  output logic [g_w-1:0] q
);

  logic load;

  // Data only moves with a live, unkilled operation so q keeps the last result.
  assign load = vld_in & ~stall & ~kill;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= 1'b0;
    end else if (kill) begin
      vld <= 1'b0;
    end else if (!stall) begin
      vld <= vld_in;
    end
  end

  generate
    if (g_rst_data) begin : g_rst
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          q <= '0;
        end else if (load) begin
          q <= d;
        end
      end
    end else begin : g_norst
      always_ff @(posedge clk) begin
        if (load) begin
          q <= d;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/rv_mul_pipeline.sv
// Fully pipelined MUL/MULH/MULHSU/MULHU unit with stall hold, kill flush and stall request.
module rv_mul_pipeline #(
  parameter int g_width   = 32,
  parameter int g_latency = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  rv_mul_pipeline_if.slave    bus
);
  import rv_mul_pipeline_pkg::*;

  localparam int PW = 2 * g_width + 1;

  mul_dec_t                      dec;
  logic signed [2*g_width-1:0]   a_wide;
  logic signed [2*g_width-1:0]   b_wide;
  logic signed [2*g_width-1:0]   prod;
  logic                          accept;
  logic [PW-1:0]                 data_p [g_latency];
  logic                          vld_p  [g_latency];
  logic [g_width-1:0]            result;
  logic                          stall_req;

  // Extending to 2*g_width and multiplying modulo 2^(2*g_width) equals the
  // (g_width+1)-bit signed product truncated to 2*g_width bits.
  function automatic logic signed [2*g_width-1:0] extend(input logic [g_width-1:0] v,
                                                         input logic sgn);
    return $signed({{g_width{sgn & v[g_width-1]}}, v});
  endfunction

  always_comb begin
    dec    = mul_decode(bus.d_fun_i);
    a_wide = extend(bus.d_rs1_i, dec.sign_a);
    b_wide = extend(bus.d_rs2_i, dec.sign_b);
    prod   = a_wide * b_wide;
  end

  assign accept    = bus.d_valid_i & bus.d_is_mul_i & ~bus.x_stall_i & ~bus.x_kill_i;
  assign data_p[0] = {dec.low_word, prod};
  assign vld_p[0]  = accept;

  // Stage 0 captures the product; later stages are pure delay.
  genvar i;
  generate
    for (i = 0; i < g_latency - 1; i++) begin : g_stage
      rv_mul_pipe_reg #(.g_w(PW), .g_rst_data(1'b0)) u_reg (
        .clk    (clk_i),
        .rst    (rst_i),
        .stall  (bus.x_stall_i),
        .kill   (bus.x_kill_i),
        .vld_in (vld_p[i]),
        .d      (data_p[i]),
        .vld    (vld_p[i+1]),
        .q      (data_p[i+1])
      );
    end
  endgenerate

  // Output register: word select travels with the op so it always matches its product.
  assign result = data_p[g_latency-1][PW-1] ? data_p[g_latency-1][g_width-1:0]
                                            : data_p[g_latency-1][2*g_width-1:g_width];

  rv_mul_pipe_reg #(.g_w(g_width), .g_rst_data(1'b1)) u_out (
    .clk    (clk_i),
    .rst    (rst_i),
    .stall  (bus.x_stall_i),
    .kill   (bus.x_kill_i),
    .vld_in (vld_p[g_latency-1]),
    .d      (result),
    .vld    (bus.x_valid_o),
    .q      (bus.x_rd_o)
  );

  always_comb begin
    stall_req = 1'b0;
    for (int k = 1; k < g_latency; k++) begin
      stall_req = stall_req | vld_p[k];
    end
  end

  assign bus.x_stall_req_o = stall_req;

endmodule

// File: tb/tb_rv_mul_pipeline.sv
// Bench for rv_mul_pipeline: three configurations (32/2, 64/4, 32/1) driven in lockstep.
module tb_rv_mul_pipeline;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rv_mul_pipeline_if #(.g_width(32)) ifa ();
  rv_mul_pipeline_if #(.g_width(64)) ifb ();
  rv_mul_pipeline_if #(.g_width(32)) ifc ();

  rv_mul_pipeline #(.g_width(32), .g_latency(2)) dut_a (.clk_i(clk), .rst_i(rst), .bus(ifa));
  rv_mul_pipeline #(.g_width(64), .g_latency(4)) dut_b (.clk_i(clk), .rst_i(rst), .bus(ifb));
  rv_mul_pipeline #(.g_width(32), .g_latency(1)) dut_c (.clk_i(clk), .rst_i(rst), .bus(ifc));

  int checks = 0;
  int errors = 0;

  localparam int NDUT  = 3;
  localparam int SLOTS = 8;
  int lat [NDUT] = '{2, 4, 1};
  int wid [NDUT] = '{32, 64, 32};

  // Reference: each in-flight op with its count of advancing edges since acceptance.
  bit          live   [NDUT][SLOTS];
  int          age    [NDUT][SLOTS];
  logic [63:0] res    [NDUT][SLOTS];
  logic [63:0] exp_rd [NDUT];

  bit          in_v, in_m, in_s, in_k;
  logic [2:0]  in_f;
  logic [63:0] in_a, in_b;

  function automatic logic [63:0] ref_result(input int w, input logic [2:0] fun,
                                             input logic [63:0] a, input logic [63:0] b);
    logic signed [129:0] ea, eb, p;
    bit sa, sb;
    sa = (fun == 3'd0) || (fun == 3'd1) || (fun == 3'd2);
    sb = (fun == 3'd0) || (fun == 3'd1);
    if (w == 32) begin
      if (sa) ea = {{98{a[31]}}, a[31:0]}; else ea = {98'd0, a[31:0]};
      if (sb) eb = {{98{b[31]}}, b[31:0]}; else eb = {98'd0, b[31:0]};
      p = ea * eb;
      return (fun == 3'd0) ? {32'd0, p[31:0]} : {32'd0, p[63:32]};
    end else begin
      if (sa) ea = {{66{a[63]}}, a}; else ea = {66'd0, a};
      if (sb) eb = {{66{b[63]}}, b}; else eb = {66'd0, b};
      p = ea * eb;
      return (fun == 3'd0) ? p[63:0] : p[127:64];
    end
  endfunction

  task automatic model_clear();
    for (int d = 0; d < NDUT; d++) begin
      for (int s = 0; s < SLOTS; s++) live[d][s] = 1'b0;
      exp_rd[d] = '0;
    end
  endtask

  task automatic model_edge();
    bit acc;
    bit placed;
    acc = in_v && in_m && !in_s && !in_k;
    for (int d = 0; d < NDUT; d++) begin
      if (in_k) begin
        for (int s = 0; s < SLOTS; s++) live[d][s] = 1'b0;
      end else if (!in_s) begin
        for (int s = 0; s < SLOTS; s++) begin
          if (live[d][s]) begin
            age[d][s]++;
            if (age[d][s] > lat[d]) live[d][s] = 1'b0;
          end
        end
        placed = 1'b0;
        if (acc) begin
          for (int s = 0; s < SLOTS; s++) begin
            if (!placed && !live[d][s]) begin
              live[d][s] = 1'b1;
              age[d][s]  = 1;
              res[d][s]  = ref_result(wid[d], in_f, in_a, in_b);
              placed     = 1'b1;
            end
          end
        end
        for (int s = 0; s < SLOTS; s++) begin
          if (live[d][s] && age[d][s] == lat[d]) exp_rd[d] = res[d][s];
        end
      end
    end
  endtask

  function automatic bit exp_valid(input int d);
    bit r = 1'b0;
    for (int s = 0; s < SLOTS; s++) if (live[d][s] && age[d][s] == lat[d]) r = 1'b1;
    return r;
  endfunction

  function automatic bit exp_busy(input int d);
    bit r = 1'b0;
    for (int s = 0; s < SLOTS; s++) if (live[d][s] && age[d][s] < lat[d]) r = 1'b1;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("a_valid", 64'(ifa.x_valid_o),     64'(exp_valid(0)));
    chk("a_rd",    64'(ifa.x_rd_o),        exp_rd[0]);
    chk("a_sreq",  64'(ifa.x_stall_req_o), 64'(exp_busy(0)));
    chk("b_valid", 64'(ifb.x_valid_o),     64'(exp_valid(1)));
    chk("b_rd",    ifb.x_rd_o,             exp_rd[1]);
    chk("b_sreq",  64'(ifb.x_stall_req_o), 64'(exp_busy(1)));
    chk("c_valid", 64'(ifc.x_valid_o),     64'(exp_valid(2)));
    chk("c_rd",    64'(ifc.x_rd_o),        exp_rd[2]);
    chk("c_sreq",  64'(ifc.x_stall_req_o), 64'(exp_busy(2)));
  endtask

  task automatic drive(input bit v, input bit m, input logic [2:0] f,
                       input logic [63:0] a, input logic [63:0] b, input bit s, input bit k);
    in_v = v; in_m = m; in_f = f; in_a = a; in_b = b; in_s = s; in_k = k;
    ifa.d_valid_i = v; ifa.d_is_mul_i = m; ifa.d_fun_i = f;
    ifa.d_rs1_i = a[31:0]; ifa.d_rs2_i = b[31:0]; ifa.x_stall_i = s; ifa.x_kill_i = k;
    ifb.d_valid_i = v; ifb.d_is_mul_i = m; ifb.d_fun_i = f;
    ifb.d_rs1_i = a; ifb.d_rs2_i = b; ifb.x_stall_i = s; ifb.x_kill_i = k;
    ifc.d_valid_i = v; ifc.d_is_mul_i = m; ifc.d_fun_i = f;
    ifc.d_rs1_i = a[31:0]; ifc.d_rs2_i = b[31:0]; ifc.x_stall_i = s; ifc.x_kill_i = k;
  endtask

  task automatic idle(input bit s, input bit k);
    drive(1'b0, 1'b0, 3'd0, 64'd0, 64'd0, s, k);
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic async_reset();
    #2;
    rst = 1'b1;
    model_clear();
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic single(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b,
                        input logic [31:0] want, input string tag);
    drive(1'b1, 1'b1, f, a, b, 1'b0, 1'b0);
    step();
    chk({tag, "_busy"}, 64'(ifa.x_stall_req_o), 64'd1);
    idle(1'b0, 1'b0);
    step();
    chk(tag, 64'(ifa.x_rd_o), 64'(want));
    chk({tag, "_pulse"}, 64'(ifa.x_valid_o), 64'd1);
    step();
    chk({tag, "_end"}, 64'(ifa.x_valid_o), 64'd0);
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return '1;
      2:       return 64'h8000_0000_8000_0000;
      3:       return 64'd1;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    rst = 1'b1;
    idle(1'b0, 1'b0);
    model_clear();
    repeat (2) @(negedge clk);
    check_all();
    chk("rst_rd_b", ifb.x_rd_o, 64'd0);
    rst = 1'b0;

    single(3'd0, '1, '1, 32'h0000_0001, "mul_ones");
    single(3'd1, 64'h8000_0000, 64'h8000_0000, 32'h4000_0000, "mulh_min");
    single(3'd3, '1, '1, 32'hFFFF_FFFE, "mulhu_ones");
    single(3'd2, '1, '1, 32'hFFFF_FFFF, "mulhsu_ones");
    single(3'd1, '1, '1, 32'h0000_0000, "mulh_ones");

    // Back-to-back issue
    drive(1'b1, 1'b1, 3'd0, 64'd3, 64'd5, 1'b0, 1'b0);
    step();
    drive(1'b1, 1'b1, 3'd3, 64'h10000, 64'h10000, 1'b0, 1'b0);
    step();
    chk("b2b_first", 64'(ifa.x_rd_o), 64'd15);
    idle(1'b0, 1'b0);
    step();
    chk("b2b_second", 64'(ifa.x_rd_o), 64'd1);
    chk("b2b_pulse2", 64'(ifa.x_valid_o), 64'd1);
    step();

    // Stall in mid-pipe
    drive(1'b1, 1'b1, 3'd0, 64'd7, 64'd6, 1'b0, 1'b0);
    step();
    idle(1'b1, 1'b0);
    repeat (3) step();
    chk("stall_hold_busy", 64'(ifa.x_stall_req_o), 64'd1);
    idle(1'b0, 1'b0);
    step();
    chk("stall_result", 64'(ifa.x_rd_o), 64'd42);
    // Stall overlapping the output pulse
    drive(1'b1, 1'b1, 3'd0, 64'd2, 64'd9, 1'b0, 1'b0);
    step();
    idle(1'b0, 1'b0);
    step();
    idle(1'b1, 1'b0);
    repeat (2) step();
    chk("stall_pulse_held", 64'(ifa.x_valid_o), 64'd1);
    chk("stall_pulse_rd", 64'(ifa.x_rd_o), 64'd18);
    idle(1'b0, 1'b0);
    step();

    // Kill, kill with stall, kill with simultaneous issue
    drive(1'b1, 1'b1, 3'd0, 64'd5, 64'd5, 1'b0, 1'b0);
    step();
    idle(1'b0, 1'b1);
    step();
    chk("kill_busy", 64'(ifa.x_stall_req_o), 64'd0);
    idle(1'b0, 1'b0);
    step();
    chk("kill_nopulse", 64'(ifa.x_valid_o), 64'd0);
    drive(1'b1, 1'b1, 3'd0, 64'd11, 64'd3, 1'b0, 1'b0);
    step();
    idle(1'b1, 1'b1);
    step();
    idle(1'b0, 1'b0);
    repeat (2) step();
    drive(1'b1, 1'b1, 3'd0, 64'd4, 64'd4, 1'b0, 1'b1);
    step();
    idle(1'b0, 1'b0);
    repeat (2) step();

    // Reset mid-operation
    drive(1'b1, 1'b1, 3'd0, 64'd9, 64'd9, 1'b0, 1'b0);
    step();
    idle(1'b0, 1'b0);
    async_reset();
    chk("rst_mid_rd", 64'(ifa.x_rd_o), 64'd0);
    repeat (3) step();

    // Wide configuration: MULHU all-ones x 2 through four stages
    drive(1'b1, 1'b1, 3'd3, '1, 64'd2, 1'b0, 1'b0);
    step();
    idle(1'b0, 1'b0);
    repeat (3) step();
    chk("w64_mulhu", ifb.x_rd_o, 64'd1);
    chk("w64_pulse", 64'(ifb.x_valid_o), 64'd1);
    step();

    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 8,
            ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3)),
            pick(), pick(), $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 5);
      if ($urandom_range(0, 199) == 0) async_reset();
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
